// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, state enum and decode helpers
// for the load/store sequencer (lsu_mem_ctrl).
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_RESP
  } lsu_state_e;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) ||
             (f3 == F3_W);
    return (f3 == F3_B)  || (f3 == F3_H)  ||
           (f3 == F3_W)  || (f3 == F3_BU) ||
           (f3 == F3_HU);
  endfunction

  // Halfword crossing a word, or word not word-aligned.
  function automatic logic f3_misal(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    return ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
           ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store shift/strobe generation and load
// extract/extend over a 64-bit read window.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [63:0] i_rwin,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_strb,
  output logic [31:0] o_rdata
);

  logic [4:0]  w_bsh;
  logic [3:0]  w_base;
  logic [31:0] w_rsh;

  assign w_bsh   = {i_off, 3'b000};
  assign o_wdata = {32'd0, i_wdata} << w_bsh;
  assign o_strb  = {4'd0, w_base} << i_off;
  assign w_rsh   = 32'(i_rwin >> w_bsh);

  // strobe base pattern from access size
  always_comb begin
    w_base = STRB_W;
    unique case (1'b1)
      (i_f3[1:0] == 2'b00): w_base = STRB_B;
      (i_f3[1:0] == 2'b01): w_base = STRB_H;
      default:              w_base = STRB_W;
    endcase
  end

  // load extract and sign/zero extend
  always_comb begin
    o_rdata = w_rsh;
    case (i_f3)
      F3_B:  o_rdata = {{24{w_rsh[7]}}, w_rsh[7:0]};
      F3_H:  o_rdata = {{16{w_rsh[15]}}, w_rsh[15:0]};
      F3_BU: o_rdata = {24'd0, w_rsh[7:0]};
      F3_HU: o_rdata = {16'd0, w_rsh[15:0]};
      default: o_rdata = w_rsh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store sequencer to data memory.
// Option MISALIGN_SPLIT_EN: split misaligned accesses in two.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_func3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              lsu_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYC);

  lsu_state_e        r_state, w_state_n;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_split;
  logic [31:0]       r_whi, r_lo;
  logic [3:0]        r_shi;
  logic [15:0]       r_cnt, w_cnt_n, w_cnt_inc;
  logic              r_req, w_req_n;
  logic              r_we, w_we_n;
  logic [ADDR_W-1:0] r_addr, w_addr_n;
  logic [31:0]       r_wdata, w_wdata_n;
  logic [3:0]        r_strb, w_strb_n;
  logic              r_done, w_done_n;
  logic [31:0]       r_rdata, w_rdata_n;
  logic              r_err, w_err_n;

  logic              w_idle, w_acc, w_to;
  logic              w_ill, w_mis;
  logic              w_split, w_bad;
  logic [2:0]        w_f3;
  logic [1:0]        w_off;
  logic [63:0]       w_rwin, w_al_wdata;
  logic [7:0]        w_al_strb;
  logic [31:0]       w_al_rdata;

  assign w_idle    = (r_state == S_IDLE);
  assign w_acc     = lsu_valid & w_idle;
  assign w_ill     = !f3_legal(lsu_we, lsu_func3);
  assign w_mis     = f3_misal(lsu_func3, lsu_addr[1:0]);
  assign w_f3      = w_idle ? lsu_func3 : r_f3;
  assign w_off     = w_idle ? lsu_addr[1:0] : r_off;
  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_to      = (w_cnt_inc == TO_CNT);
  assign w_rwin    = (r_state == S_ACC1) ?
                     {mem_rdata, r_lo} :
                     {32'd0, mem_rdata};

`ifdef MISALIGN_SPLIT_EN
  assign w_split = w_mis;
  assign w_bad   = w_ill;
`else
  assign w_split = 1'b0;
  assign w_bad   = w_ill | w_mis;
`endif

  lsu_align u_align (
    .i_f3    (w_f3),
    .i_off   (w_off),
    .i_wdata (lsu_wdata),
    .i_rwin  (w_rwin),
    .o_wdata (w_al_wdata),
    .o_strb  (w_al_strb),
    .o_rdata (w_al_rdata)
  );

  assign lsu_ready = w_idle;
  assign lsu_done  = r_done;
  assign lsu_rdata = r_rdata;
  assign lsu_err   = r_err;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_strb;

  // state, registered outputs and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_strb  <= w_strb_n;
      r_done  <= w_done_n;
      r_rdata <= w_rdata_n;
      r_err   <= w_err_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // capture request context and first read word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3    <= '0;
      r_off   <= '0;
      r_split <= 1'b0;
      r_whi   <= '0;
      r_shi   <= '0;
      r_lo    <= '0;
    end else begin
      if (w_acc) begin
        r_f3    <= lsu_func3;
        r_off   <= lsu_addr[1:0];
        r_split <= w_split;
        r_whi   <= w_al_wdata[63:32];
        r_shi   <= w_al_strb[7:4];
      end
      if ((r_state == S_ACC0) && mem_ack)
        r_lo <= mem_rdata;
    end
  end

  // next state and next registered outputs
  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_we_n    = r_we;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_strb_n  = r_strb;
    w_done_n  = 1'b0;
    w_rdata_n = '0;
    w_err_n   = 1'b0;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (lsu_valid) begin
          if (w_bad) begin
            w_state_n = S_RESP;
            w_done_n  = 1'b1;
            w_err_n   = 1'b1;
          end else begin
            w_state_n = S_ACC0;
            w_req_n   = 1'b1;
            w_we_n    = lsu_we;
            w_addr_n  = {lsu_addr[ADDR_W-1:2], 2'b00};
            w_wdata_n = lsu_we ? w_al_wdata[31:0] : '0;
            w_strb_n  = lsu_we ? w_al_strb[3:0] : '0;
            w_cnt_n   = '0;
          end
        end
      end
      S_ACC0, S_ACC1: begin
        if (mem_ack) begin
          if ((r_state == S_ACC0) && r_split) begin
            w_state_n = S_ACC1;
            w_addr_n  = r_addr + ADDR_W'(4);
            w_wdata_n = r_we ? r_whi : '0;
            w_strb_n  = r_we ? r_shi : '0;
            w_cnt_n   = '0;
          end else begin
            w_state_n = S_RESP;
            w_req_n   = 1'b0;
            w_done_n  = 1'b1;
            w_rdata_n = r_we ? '0 : w_al_rdata;
          end
        end else if (w_to) begin
          w_state_n = S_RESP;
          w_req_n   = 1'b0;
          w_done_n  = 1'b1;
          w_err_n   = 1'b1;
        end else begin
          w_cnt_n = w_cnt_inc;
        end
      end
      S_RESP:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a
// memory responder; second instance exercises timeout/reset.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  int          cyc = 0;

  logic        lsu_valid = 1'b0, v2 = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_func3 = '0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic        lsu_ready, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        ready2, done2, err2, req2, we2;
  logic [31:0] rdata2, addr2, wdata2;
  logic [3:0]  strb2;
  logic        ack2 = 1'b0;
  logic [31:0] mrd2 = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t0;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] rw;
  } beat_t;

  exp_t  sb[$];
  beat_t bq[$];
  int    errs = 0;
  int    checks = 0;
  int    ack_dly = 0;
  int    wcnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_we(lsu_we), .lsu_func3(lsu_func3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  lsu_mem_ctrl #(.TIMEOUT_CYC(4)) dut2 (
    .clk(clk), .rst(rst2),
    .lsu_valid(v2), .lsu_ready(ready2),
    .lsu_we(lsu_we), .lsu_func3(lsu_func3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(done2), .lsu_rdata(rdata2),
    .lsu_err(err2),
    .mem_req(req2), .mem_we(we2),
    .mem_addr(addr2), .mem_wdata(wdata2),
    .mem_wstrb(strb2),
    .mem_ack(ack2), .mem_rdata(mrd2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // memory responder: checks each beat, acks after ack_dly
  always @(negedge clk) begin
    beat_t b;
    if (mem_req) begin
      if (wcnt < ack_dly) begin
        wcnt++;
        mem_ack = 1'b0;
      end else if (bq.size() == 0) begin
        chk("unexp_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1;
        mem_rdata = '0;
        wcnt = 0;
      end else begin
        b = bq.pop_front();
        chk("maddr", mem_addr, b.addr);
        chk("mwe", {31'd0, mem_we}, {31'd0, b.we});
        if (b.we) begin
          chk("mwdata", mem_wdata, b.wdata);
          chk("mwstrb", {28'd0, mem_wstrb}, {28'd0, b.strb});
        end
        chk("busy_rdy", {31'd0, lsu_ready}, 32'd0);
        mem_ack = 1'b1;
        mem_rdata = b.rw;
        wcnt = 0;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  // completion monitor: pop scoreboard on each done pulse
  always @(negedge clk) begin
    exp_t e;
    if (lsu_done) begin
      if (sb.size() == 0) begin
        chk("spur_done", {31'd0, lsu_done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rdata", lsu_rdata, e.rdata);
        chk("err", {31'd0, lsu_err}, {31'd0, e.err});
        chk("lat", 32'(cyc - e.t0), 32'(e.lat));
      end
    end
  end

  task automatic push_beat(
    input logic [31:0] a,
    input logic        we,
    input logic [31:0] wd,
    input logic [3:0]  st,
    input logic [31:0] rw
  );
    beat_t b;
    b.addr = a; b.we = we; b.wdata = wd;
    b.strb = st; b.rw = rw;
    bq.push_back(b);
  endtask

  task automatic issue(
    input logic        we,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input int          dly,
    input logic [31:0] er,
    input logic        ee,
    input int          lat
  );
    exp_t e;
    int n;
    ack_dly = dly;
    @(negedge clk);
    lsu_we = we; lsu_func3 = f3;
    lsu_addr = a; lsu_wdata = wd;
    lsu_valid = 1'b1;
    n = 0;
    while (!lsu_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    e.rdata = er; e.err = ee;
    e.t0 = cyc; e.lat = lat;
    sb.push_back(e);
    @(posedge clk);
    #1 lsu_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(sb.size()), 32'd0);
    chk("beats_left", 32'(bq.size()), 32'd0);
    sb.delete();
    bq.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, hi, dn, t0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    chk("rst_rdy", {31'd0, lsu_ready}, 32'd1);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_strb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_done", {31'd0, lsu_done}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_err", {31'd0, lsu_err}, 32'd0);

    push_beat(32'h1000, 1, 32'hA500_0000, 4'b1000, 0);
    issue(1, F3_B, 32'h1003, 32'h0000_00A5,
          0, 32'h0, 0, 2);
    push_beat(32'h2000, 0, 0, 0, 32'h0080_FF00);
    issue(0, F3_B, 32'h2002, 0,
          0, 32'hFFFF_FF80, 0, 2);
    push_beat(32'h2000, 0, 0, 0, 32'h0080_FF00);
    issue(0, F3_BU, 32'h2002, 0,
          0, 32'h0000_0080, 0, 2);
    push_beat(32'h10, 0, 0, 0, 32'h1234_ABCD);
    issue(0, F3_H, 32'h10, 0,
          5, 32'hFFFF_ABCD, 0, 7);
    issue(0, 3'b011, 32'h20, 0,
          0, 32'h0, 1, 1);
    push_beat(32'h100, 1, 32'hBEEF_0000, 4'b1100, 0);
    issue(1, F3_H, 32'h102, 32'h0000_BEEF,
          0, 32'h0, 0, 2);
    push_beat(32'h304, 0, 0, 0, 32'h8001_7FFF);
    issue(0, F3_HU, 32'h306, 0,
          0, 32'h0000_8001, 0, 2);
    push_beat(32'h400, 0, 0, 0, 32'hCAFE_F00D);
    issue(0, F3_W, 32'h400, 0,
          2, 32'hCAFE_F00D, 0, 4);
    push_beat(32'h500, 1, 32'h1122_3344, 4'b1111, 0);
    issue(1, F3_W, 32'h500, 32'h1122_3344,
          0, 32'h0, 0, 2);
    issue(1, 3'b011, 32'h600, 32'h1,
          0, 32'h0, 1, 1);
    issue(1, 3'b100, 32'h600, 32'h1,
          0, 32'h0, 1, 1);
    push_beat(32'h0, 0, 0, 0, 32'h7F00_0000);
    issue(0, F3_B, 32'h3, 0,
          0, 32'h0000_007F, 0, 2);
    push_beat(32'h200, 0, 0, 0, 32'h0080_0000);
    issue(0, F3_H, 32'h201, 0,
          1, 32'hFFFF_8000, 0, 3);

`ifdef MISALIGN_SPLIT_EN
    push_beat(32'hFFFF_FFFC, 1, 32'hBBAA_0000, 4'b1100, 0);
    push_beat(32'h0000_0000, 1, 32'h0000_DDCC, 4'b0011, 0);
    issue(1, F3_W, 32'hFFFF_FFFE, 32'hDDCC_BBAA,
          0, 32'h0, 0, 3);
    push_beat(32'h100, 0, 0, 0, 32'hAB00_0000);
    push_beat(32'h104, 0, 0, 0, 32'h0000_00CD);
    issue(0, F3_H, 32'h103, 0,
          0, 32'hFFFF_CDAB, 0, 3);
`else
    issue(1, F3_W, 32'hFFFF_FFFE, 32'hDDCC_BBAA,
          0, 32'h0, 1, 1);
    issue(0, F3_H, 32'h103, 0,
          0, 32'h0, 1, 1);
`endif

    @(negedge clk);
    lsu_we = 1'b0; lsu_func3 = F3_W;
    lsu_addr = 32'h40; v2 = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 v2 = 1'b0;
    hi = 0; n = 0;
    while (!done2 && n < 50) begin
      @(negedge clk);
      if (req2) hi++;
      n++;
    end
    chk("to_done", {31'd0, done2}, 32'd1);
    chk("to_req_cyc", 32'(hi), 32'd4);
    chk("to_err", {31'd0, err2}, 32'd1);
    chk("to_rdata", rdata2, 32'd0);
    chk("to_lat", 32'(cyc - t0), 32'd5);

    @(negedge clk);
    lsu_addr = 32'h80; v2 = 1'b1;
    @(posedge clk);
    #1 v2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_pre", {31'd0, req2}, 32'd1);
    rst2 = 1'b1;
    @(negedge clk);
    chk("mid_req", {31'd0, req2}, 32'd0);
    rst2 = 1'b0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done2) dn++;
    end
    chk("mid_nodone", 32'(dn), 32'd0);
    chk("mid_rdy", {31'd0, ready2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
